// File: rtl/muldiv_sequencer.sv
// Multi-cycle signed MULT/DIV sequencer that owns the HI/LO registers.
// Optional feature: define MULDIV_FAST_ZERO_EN to skip iteration when an operand is zero.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MULT,
    S_DIV,
    S_DONE,
    S_DZERO
  } state_t;

  state_t state_q, state_d;

  // Shared iteration registers: acc is the Booth accumulator (one guard bit)
  // or the division remainder; shr is the multiplier or the dividend/quotient.
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] shr;
  logic [WIDTH-1:0] opnd;
  logic             booth_q1;
  logic             neg_q;
  logic             neg_r;
  logic [CW-1:0]    count;
  logic             last_step;

  logic             fast_mult;
  logic             fast_div;

`ifdef MULDIV_FAST_ZERO_EN
  assign fast_mult = (a_in == '0) || (b_in == '0);
  assign fast_div  = (a_in == '0);
`else
  assign fast_mult = 1'b0;
  assign fast_div  = 1'b0;
`endif

  assign last_step = (count == CW'(1));

  // Radix-2 Booth step followed by an arithmetic shift of {acc, shr, q1}.
  logic [WIDTH:0]   opnd_ext;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   mult_acc;
  logic [WIDTH-1:0] mult_shr;

  assign opnd_ext = {opnd[WIDTH-1], opnd};

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
    booth_sum = acc;
    case ({shr[0], booth_q1})
      2'b01:   booth_sum = acc + opnd_ext;
      2'b10:   booth_sum = acc - opnd_ext;
      default: booth_sum = acc;
    endcase
  end

  assign mult_acc = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
  assign mult_shr = {booth_sum[0], shr[WIDTH-1:1]};

  // Restoring division step on magnitudes: the remainder always stays below the divisor.
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] div_quo;

  assign div_shift = {acc[WIDTH-1:0], shr[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, opnd});
  assign div_rem   = div_ge ? WIDTH'(div_shift - {1'b0, opnd}) : div_shift[WIDTH-1:0];
  assign div_quo   = {shr[WIDTH-2:0], div_ge};

  // Next state and control outputs.
  always_comb begin
    state_d  = state_q;
    busy     = 1'b0;
    done     = 1'b0;
    div_zero = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_mult) begin
          state_d = fast_mult ? S_DONE : S_MULT;
        end else if (start_div) begin
          if (b_in == '0)    state_d = S_DZERO;
          else if (fast_div) state_d = S_DONE;
          else               state_d = S_DIV;
        end
      end
      S_MULT: begin
        busy = 1'b1;
        if (last_step) state_d = S_DONE;
      end
      S_DIV: begin
        busy = 1'b1;
        if (last_step) state_d = S_DONE;
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_DZERO: begin
        div_zero = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // HI/LO are written only on entry to DONE, so partial results never leak.
  logic             res_load;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  always_comb begin
    res_load = 1'b0;
    res_hi   = '0;
    res_lo   = '0;
    if (state_q == S_IDLE && state_d == S_DONE) begin
      res_load = 1'b1;
    end else if (state_q == S_MULT && last_step) begin
      res_load = 1'b1;
      res_hi   = mult_acc[WIDTH-1:0];
      res_lo   = mult_shr;
    end else if (state_q == S_DIV && last_step) begin
      res_load = 1'b1;
      res_hi   = neg_r ? -div_rem : div_rem;
      res_lo   = neg_q ? -div_quo : div_quo;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc      <= '0;
      shr      <= '0;
      opnd     <= '0;
      booth_q1 <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      count    <= '0;
      hi_out   <= '0;
      lo_out   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (state_d == S_MULT) begin
            acc      <= '0;
            shr      <= b_in;
            opnd     <= a_in;
            booth_q1 <= 1'b0;
            count    <= CW'(WIDTH);
          end else if (state_d == S_DIV) begin
            acc   <= '0;
            shr   <= a_in[WIDTH-1] ? -a_in : a_in;
            opnd  <= b_in[WIDTH-1] ? -b_in : b_in;
            neg_q <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
            neg_r <= a_in[WIDTH-1];
            count <= CW'(WIDTH);
          end
        end
        S_MULT: begin
          acc      <= mult_acc;
          shr      <= mult_shr;
          booth_q1 <= shr[0];
          count    <= count - CW'(1);
        end
        S_DIV: begin
          acc   <= {1'b0, div_rem};
          shr   <= div_quo;
          count <= count - CW'(1);
        end
        default: ;
      endcase
      if (res_load) begin
        hi_out <= res_hi;
        lo_out <= res_lo;
      end
    end
  end

endmodule
